// File: rtl/cpu_types_pkg.sv
// Shared types for the MIPS core front end: machine word, fetch FSM states
// and the PC step/alignment helpers.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HOLD = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam word_t PC_STEP = 32'd4;

    // Instruction addresses are word aligned; low two bits are dropped.
    function automatic word_t align_word(input word_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_perf_ctr.sv
// Saturating event counter with synchronous clear and increment enable.
module fetch_perf_ctr #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

    logic [WIDTH-1:0] r_count;

    // Count events, sticking at all-ones instead of wrapping.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_count <= {WIDTH{1'b0}};
        end else if (i_inc && (r_count != CNT_MAX)) begin
            r_count <= r_count + CNT_ONE;
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, I-cache request, one-entry skid, IF/ID register.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic [31:0] iload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        hu_stall,
    input  logic        hu_flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_npc,
    output logic        ifid_valid,
    output logic        halted,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_miss
);

    fetch_state_t r_state;
    fetch_state_t w_next_state;
    word_t        r_pc;
    word_t        r_skid;
    word_t        r_ifid_instr;
    word_t        r_ifid_npc;
    logic         r_ifid_valid;

    logic  w_imem_ren;
    logic  w_halted;
    logic  w_adv_run;
    logic  w_to_hold;
    logic  w_adv_hold;
    word_t w_pc_plus4;

    assign w_pc_plus4 = r_pc + PC_STEP;
    assign w_adv_run  = (r_state == RUN) && ihit && !hu_stall;
    assign w_to_hold  = (r_state == RUN) && ihit && hu_stall;
    assign w_adv_hold = (r_state == HOLD) && !hu_stall;

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: halt beats redirect, redirect beats the stall/hit cases.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            RUN: begin
                if (halt)                w_next_state = HALT;
                else if (redirect_valid) w_next_state = RUN;
                else if (w_to_hold)      w_next_state = HOLD;
                else                     w_next_state = RUN;
            end
            HOLD: begin
                if (halt)                w_next_state = HALT;
                else if (redirect_valid) w_next_state = RUN;
                else if (!hu_stall)      w_next_state = RUN;
                else                     w_next_state = HOLD;
            end
            HALT:    w_next_state = HALT;
            default: w_next_state = RUN;
        endcase
    end

    // Output decode from the state register.
    always_comb begin
        w_imem_ren = 1'b0;
        w_halted   = 1'b0;
        case (r_state)
            RUN:     w_imem_ren = !RST;
            HOLD:    w_imem_ren = 1'b0;
            HALT:    w_halted   = 1'b1;
            default: w_imem_ren = 1'b0;
        endcase
    end

    // PC, skid buffer and IF/ID register; flush only overrides the IF/ID update.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pc         <= PC_INIT;
            r_skid       <= 32'h0000_0000;
            r_ifid_instr <= 32'h0000_0000;
            r_ifid_npc   <= 32'h0000_0000;
            r_ifid_valid <= 1'b0;
        end else if (halt || (r_state == HALT)) begin
            r_ifid_valid <= 1'b0;
        end else if (redirect_valid) begin
            r_pc         <= align_word(redirect_pc);
            r_skid       <= 32'h0000_0000;
            r_ifid_valid <= 1'b0;
        end else begin
            if (w_adv_run || w_adv_hold) begin
                r_pc <= w_pc_plus4;
            end
            if (w_to_hold) begin
                r_skid <= iload;
            end
            if (hu_flush) begin
                r_ifid_valid <= 1'b0;
            end else if (w_adv_run) begin
                r_ifid_instr <= iload;
                r_ifid_npc   <= w_pc_plus4;
                r_ifid_valid <= 1'b1;
            end else if (w_adv_hold) begin
                r_ifid_instr <= r_skid;
                r_ifid_npc   <= w_pc_plus4;
                r_ifid_valid <= 1'b1;
            end else if ((r_state == RUN) && !ihit && !hu_stall) begin
                r_ifid_valid <= 1'b0;
            end
        end
    end

    assign imemREN    = w_imem_ren;
    assign imemaddr   = r_pc;
    assign halted     = w_halted;
    assign ifid_instr = r_ifid_instr;
    assign ifid_npc   = r_ifid_npc;
    assign ifid_valid = r_ifid_valid;

`ifdef FETCH_PERF_EN
    logic w_inc_fetched;
    logic w_inc_stall;
    logic w_inc_miss;

    assign w_inc_fetched = !halt && (r_state != HALT) && !redirect_valid &&
                           !hu_flush && (w_adv_run || w_adv_hold);
    assign w_inc_stall   = hu_stall && (r_state != HALT);
    assign w_inc_miss    = (r_state == RUN) && w_imem_ren && !ihit;

    fetch_perf_ctr #(.WIDTH(32)) u_ctr_fetched (
        .i_clk(CLK), .i_clr(RST), .i_inc(w_inc_fetched), .o_count(perf_fetched)
    );
    fetch_perf_ctr #(.WIDTH(32)) u_ctr_stall (
        .i_clk(CLK), .i_clr(RST), .i_inc(w_inc_stall), .o_count(perf_stall)
    );
    fetch_perf_ctr #(.WIDTH(32)) u_ctr_miss (
        .i_clk(CLK), .i_clr(RST), .i_inc(w_inc_miss), .o_count(perf_miss)
    );
`else
    assign perf_fetched = 32'h0000_0000;
    assign perf_stall   = 32'h0000_0000;
    assign perf_miss    = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit plus a narrow saturating-counter check.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ihit;
    logic [31:0] iload;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        hu_stall;
    logic        hu_flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_npc;
    logic        ifid_valid;
    logic        halted;
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
    logic [31:0] perf_miss;

    logic       c_clr;
    logic       c_inc;
    logic [3:0] c_count;

    int n_total = 0;
    int n_pass  = 0;

    always #5 CLK = ~CLK;

    fetch_unit #(.PC_INIT(32'h0000_0000)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .iload(iload),
        .imemREN(imemREN), .imemaddr(imemaddr),
        .hu_stall(hu_stall), .hu_flush(hu_flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt(halt), .ifid_instr(ifid_instr), .ifid_npc(ifid_npc),
        .ifid_valid(ifid_valid), .halted(halted),
        .perf_fetched(perf_fetched), .perf_stall(perf_stall), .perf_miss(perf_miss)
    );

    fetch_perf_ctr #(.WIDTH(4)) u_small_ctr (
        .i_clk(CLK), .i_clr(c_clr), .i_inc(c_inc), .o_count(c_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] instr,
                            input logic [31:0] npc, input logic valid);
        chk({tag, "_instr"}, ifid_instr, instr);
        chk({tag, "_npc"}, ifid_npc, npc);
        chk({tag, "_valid"}, {31'd0, ifid_valid}, {31'd0, valid});
    endtask

    initial begin
        RST = 1'b1; ihit = 1'b0; iload = 32'h0; hu_stall = 1'b0; hu_flush = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; halt = 1'b0;
        c_clr = 1'b1; c_inc = 1'b0;
        step(); step();

        // Reset state
        chk("rst_ren", {31'd0, imemREN}, 32'd0);
        chk("rst_addr", imemaddr, 32'h0000_0000);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk_ifid("rst", 32'h0, 32'h0, 1'b0);
        chk("rst_pf", perf_fetched, 32'd0);

        // First fetch
        RST = 1'b0;
        #1;
        chk("run_ren", {31'd0, imemREN}, 32'd1);
        chk("run_addr0", imemaddr, 32'h0);
        ihit = 1'b1; iload = 32'h8C22_0004;
        step();
        chk_ifid("fetch1", 32'h8C22_0004, 32'h4, 1'b1);
        chk("fetch1_addr", imemaddr, 32'h4);

        // Hit during stall goes to skid / HOLD
        iload = 32'h0022_1820; hu_stall = 1'b1;
        step();
        chk("hold_ren", {31'd0, imemREN}, 32'd0);
        chk_ifid("hold", 32'h8C22_0004, 32'h4, 1'b1);
        chk("hold_addr", imemaddr, 32'h4);
        ihit = 1'b0;
        step();
        chk("hold2_ren", {31'd0, imemREN}, 32'd0);
        chk_ifid("hold2", 32'h8C22_0004, 32'h4, 1'b1);
        hu_stall = 1'b0;
        step();
        chk_ifid("release", 32'h0022_1820, 32'h8, 1'b1);
        chk("release_addr", imemaddr, 32'h8);
        chk("release_ren", {31'd0, imemREN}, 32'd1);

        // Redirect while in HOLD with stall still high discards the skid
        ihit = 1'b1; iload = 32'hDEAD_BEEF; hu_stall = 1'b1;
        step();
        chk("hold3_ren", {31'd0, imemREN}, 32'd0);
        ihit = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0043;
        step();
        chk("redir_valid", {31'd0, ifid_valid}, 32'd0);
        chk("redir_addr", imemaddr, 32'h0000_0040);
        chk("redir_ren", {31'd0, imemREN}, 32'd1);
        redirect_valid = 1'b0; hu_stall = 1'b0;
        step();
        chk("redir_bubble", {31'd0, ifid_valid}, 32'd0);
        chk("redir_addr2", imemaddr, 32'h0000_0040);

        // Flush together with stall
        ihit = 1'b1; iload = 32'h1111_1111;
        step();
        chk_ifid("fetch44", 32'h1111_1111, 32'h44, 1'b1);
        ihit = 1'b0; hu_flush = 1'b1; hu_stall = 1'b1;
        step();
        chk("flush_valid", {31'd0, ifid_valid}, 32'd0);
        chk("flush_addr", imemaddr, 32'h44);
        hu_flush = 1'b0; hu_stall = 1'b0;

        // PC wrap
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        chk("wrap_pre", imemaddr, 32'hFFFF_FFFC);
        redirect_valid = 1'b0; ihit = 1'b1; iload = 32'h2222_2222;
        step();
        chk_ifid("wrap", 32'h2222_2222, 32'h0, 1'b1);
        chk("wrap_addr", imemaddr, 32'h0);

        // Halt is sticky and ignores hits / redirects
        iload = 32'h3333_3333; halt = 1'b1;
        step();
        chk("halt_halted", {31'd0, halted}, 32'd1);
        chk("halt_ren", {31'd0, imemREN}, 32'd0);
        chk("halt_valid", {31'd0, ifid_valid}, 32'd0);
        chk("halt_addr", imemaddr, 32'h0);
        halt = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
        step(); step();
        chk("halt2_halted", {31'd0, halted}, 32'd1);
        chk("halt2_addr", imemaddr, 32'h0);
        chk("halt2_valid", {31'd0, ifid_valid}, 32'd0);
        redirect_valid = 1'b0; ihit = 1'b0;
        RST = 1'b1;
        step();
        chk("rst2_halted", {31'd0, halted}, 32'd0);
        chk("rst2_addr", imemaddr, 32'h0);
        chk("rst2_ren", {31'd0, imemREN}, 32'd0);
        RST = 1'b0;

        // Perf scenario: 3 fetches, 2 misses, 4 stall cycles
        ihit = 1'b1; iload = 32'hA000_0001; step();
        ihit = 1'b0; step(); step();
        ihit = 1'b1; iload = 32'hA000_0002; step();
        chk_ifid("perf_f2", 32'hA000_0002, 32'h8, 1'b1);
        iload = 32'hA000_0003; hu_stall = 1'b1; step();
        ihit = 1'b0; step(); step(); step();
        hu_stall = 1'b0; step();
        chk_ifid("perf_f3", 32'hA000_0003, 32'hC, 1'b1);
        // Halt with a hit so no extra miss is counted, then idle in HALT
        ihit = 1'b1; halt = 1'b1; step();
        halt = 1'b0; ihit = 1'b0; hu_stall = 1'b1; step(); step();
        hu_stall = 1'b0;
`ifdef FETCH_PERF_EN
        chk("perf_fetched", perf_fetched, 32'd3);
        chk("perf_miss", perf_miss, 32'd2);
        chk("perf_stall", perf_stall, 32'd4);
`else
        chk("perf_fetched", perf_fetched, 32'd0);
        chk("perf_miss", perf_miss, 32'd0);
        chk("perf_stall", perf_stall, 32'd0);
`endif

        // Saturating counter on a narrow instance
        c_clr = 1'b0; c_inc = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("ctr_three", {28'd0, c_count}, 32'd3);
        for (int i = 0; i < 12; i++) step();
        chk("ctr_max", {28'd0, c_count}, 32'd15);
        for (int i = 0; i < 4; i++) step();
        chk("ctr_sat", {28'd0, c_count}, 32'd15);
        c_inc = 1'b0; c_clr = 1'b1; step();
        chk("ctr_clr", {28'd0, c_count}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
